// File: rtl/pc_stack_pkg.sv
// Shared types and sizing helpers for the PC return-address stack.
package pc_stack_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL
  } stack_state_e;

  localparam int unsigned PC_ADDR_W = 5;
  localparam int unsigned PC_DEPTH  = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/pc_return_stack_if.sv
// Push handshake, pop request/response and status bundle of the return stack.
interface pc_return_stack_if
  import pc_stack_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W,
  parameter int unsigned CNT_W  = clog2(PC_DEPTH + 1)
) ();

  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_addr;
  logic              pop_req;
  logic              pop_valid;
  logic [ADDR_W-1:0] pop_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output push_valid, push_addr, pop_req,
    input  push_ready, pop_valid, pop_addr, count, empty, full,
           overflow_err, underflow_err
  );

  modport slave (
    input  push_valid, push_addr, pop_req,
    output push_ready, pop_valid, pop_addr, count, empty, full,
           overflow_err, underflow_err
  );

endinterface

// File: rtl/pc_stack_mem.sv
// Unreset register array: one write port, one combinational read port.
module pc_stack_mem
  import pc_stack_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W,
  parameter int unsigned DEPTH  = PC_DEPTH,
  parameter int unsigned AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [ADDR_W-1:0] rdata
);

  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pc_return_stack.sv
// LIFO of return addresses for the PC sequencer: push on call, pop on return.
module pc_return_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W,
  parameter int unsigned DEPTH  = PC_DEPTH,
  parameter int unsigned CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  pc_return_stack_if.slave  bus
);

  localparam int unsigned AW = clog2(DEPTH);

  stack_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_empty, r_full;
  logic              r_pop_valid;
  logic [ADDR_W-1:0] r_pop_addr;
  logic              r_ovf, r_udf;

  logic              w_push_ready, w_push, w_pop, w_ovf, w_udf;
  logic [AW-1:0]     w_waddr, w_raddr;
  logic [ADDR_W-1:0] w_rdata;

  pc_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (w_waddr),
    .wdata (bus.push_addr),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY:  if (w_push) w_state_nxt = ACTIVE;
      ACTIVE: begin
        if (w_push && !w_pop && r_count == CNT_W'(DEPTH - 1))
          w_state_nxt = FULL;
        else if (w_pop && !w_push && r_count == CNT_W'(1))
          w_state_nxt = EMPTY;
      end
      FULL:   if (w_pop && !w_push) w_state_nxt = ACTIVE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // A combined push+pop reads the old top and rewrites the same slot.
  always_comb begin
    w_push_ready = (r_state != FULL) | bus.pop_req;
    w_push       = bus.push_valid & w_push_ready;
    w_pop        = bus.pop_req & (r_state != EMPTY);
    w_ovf        = bus.push_valid & ~w_push_ready;
    w_udf        = bus.pop_req & (r_state == EMPTY);
    w_raddr      = AW'(r_count) - AW'(1);
    w_waddr      = w_pop ? w_raddr : AW'(r_count);
    w_count_nxt  = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_pop_valid <= 1'b0;
      r_pop_addr  <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_empty     <= (w_count_nxt == '0);
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_pop_valid <= w_pop;
      r_ovf       <= w_ovf;
      r_udf       <= w_udf;
      if (w_pop) r_pop_addr <= w_rdata;
    end
  end

  assign bus.push_ready    = w_push_ready;
  assign bus.pop_valid     = r_pop_valid;
  assign bus.pop_addr      = r_pop_addr;
  assign bus.count         = r_count;
  assign bus.empty         = r_empty;
  assign bus.full          = r_full;
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_udf;

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed self-checking bench for pc_return_stack (ADDR_W=5, DEPTH=4).
module tb_pc_return_stack;

  logic clk;
  logic reset;
  int unsigned n_asserts;
  int unsigned n_fail;

  pc_return_stack_if #(.ADDR_W(5), .CNT_W(3)) bus ();

  pc_return_stack #(
    .ADDR_W (5),
    .DEPTH  (4),
    .CNT_W  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a);
    bus.push_valid = 1'b1;
    bus.push_addr  = a;
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [4:0] exp);
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    check({tag, "_valid"}, 32'(bus.pop_valid), 32'd1);
    check({tag, "_addr"}, 32'(bus.pop_addr), 32'(exp));
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset          = 1'b1;
    bus.push_valid = 1'b0;
    bus.push_addr  = '0;
    bus.pop_req    = 1'b0;
    tick();
    tick();

    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    check("rst_pop_addr", 32'(bus.pop_addr), 32'd0);
    check("rst_ovf", 32'(bus.overflow_err), 32'd0);
    check("rst_udf", 32'(bus.underflow_err), 32'd0);
    check("rst_push_ready", 32'(bus.push_ready), 32'd1);
    reset = 1'b0;
    tick();

    // LIFO order with back-to-back pops
    push(5'h03);
    push(5'h07);
    push(5'h0A);
    check("lifo_count3", 32'(bus.count), 32'd3);
    check("lifo_not_empty", 32'(bus.empty), 32'd0);
    pop_chk("lifo_pop0", 5'h0A);
    pop_chk("lifo_pop1", 5'h07);
    pop_chk("lifo_pop2", 5'h03);
    check("lifo_empty", 32'(bus.empty), 32'd1);
    check("lifo_count0", 32'(bus.count), 32'd0);
    tick();
    check("lifo_valid_pulse", 32'(bus.pop_valid), 32'd0);
    check("lifo_addr_held", 32'(bus.pop_addr), 32'h03);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) push(5'(i));
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_ready", 32'(bus.push_ready), 32'd0);
    bus.push_valid = 1'b1;
    bus.push_addr  = 5'h1F;
    #1;
    check("ovf_ready_low", 32'(bus.push_ready), 32'd0);
    tick();
    bus.push_valid = 1'b0;
    check("ovf_pulse", 32'(bus.overflow_err), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd4);
    tick();
    check("ovf_pulse_end", 32'(bus.overflow_err), 32'd0);
    pop_chk("fill_pop4", 5'h04);
    pop_chk("fill_pop3", 5'h03);
    pop_chk("fill_pop2", 5'h02);
    pop_chk("fill_pop1", 5'h01);
    check("fill_empty", 32'(bus.empty), 32'd1);

    // Simultaneous push and pop while full
    for (int i = 1; i <= 4; i++) push(5'(i));
    bus.push_valid = 1'b1;
    bus.push_addr  = 5'h11;
    bus.pop_req    = 1'b1;
    #1;
    check("sim_ready", 32'(bus.push_ready), 32'd1);
    tick();
    bus.push_valid = 1'b0;
    bus.pop_req    = 1'b0;
    check("sim_valid", 32'(bus.pop_valid), 32'd1);
    check("sim_addr", 32'(bus.pop_addr), 32'h04);
    check("sim_count", 32'(bus.count), 32'd4);
    check("sim_full", 32'(bus.full), 32'd1);
    check("sim_ovf", 32'(bus.overflow_err), 32'd0);
    check("sim_udf", 32'(bus.underflow_err), 32'd0);
    pop_chk("sim_pop11", 5'h11);
    pop_chk("sim_pop3", 5'h03);
    pop_chk("sim_pop2", 5'h02);
    pop_chk("sim_pop1", 5'h01);

    // Empty corner cases
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    check("udf_pulse", 32'(bus.underflow_err), 32'd1);
    check("udf_no_valid", 32'(bus.pop_valid), 32'd0);
    check("udf_addr_held", 32'(bus.pop_addr), 32'h01);
    check("udf_count", 32'(bus.count), 32'd0);
    tick();
    check("udf_pulse_end", 32'(bus.underflow_err), 32'd0);
    bus.push_valid = 1'b1;
    bus.push_addr  = 5'h09;
    bus.pop_req    = 1'b1;
    tick();
    bus.push_valid = 1'b0;
    bus.pop_req    = 1'b0;
    check("epush_udf", 32'(bus.underflow_err), 32'd1);
    check("epush_no_valid", 32'(bus.pop_valid), 32'd0);
    check("epush_count", 32'(bus.count), 32'd1);
    check("epush_not_empty", 32'(bus.empty), 32'd0);
    pop_chk("epush_pop9", 5'h09);

    // Reset mid-operation, before the pop response
    push(5'h05);
    push(5'h06);
    push(5'h07);
    bus.pop_req = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("mrst_count", 32'(bus.count), 32'd0);
    check("mrst_empty", 32'(bus.empty), 32'd1);
    check("mrst_valid", 32'(bus.pop_valid), 32'd0);
    tick();
    check("mrst_valid_edge", 32'(bus.pop_valid), 32'd0);
    bus.pop_req = 1'b0;
    reset = 1'b0;
    tick();
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    check("mrst_udf", 32'(bus.underflow_err), 32'd1);
    check("mrst_udf_valid", 32'(bus.pop_valid), 32'd0);

    // Reset clears an in-flight pop response
    push(5'h08);
    pop_chk("inflight_pop", 5'h08);
    #1;
    reset = 1'b1;
    #1;
    check("inflight_valid_clr", 32'(bus.pop_valid), 32'd0);
    check("inflight_addr_clr", 32'(bus.pop_addr), 32'd0);
    #2;
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
